vec_lane_sequencer: RTL
=======================

VEC_LANE_SEQUENCER -- requirements
Module: vec_lane_sequencer

Interface
REQ-001 Parameter NLANES, default 5: number of 32-bit lanes per vector register.
REQ-002 Parameter WIDTH, default 32: lane data width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a vector operation.
REQ-006 req_ready  output  1  sequencer accepts a request this cycle.
REQ-007 req_op  input  3  operation, ALUControl encoding: 000 add, 001 sub, 010 and, 011 or; 100-111 copy.
REQ-008 req_va  input  4  source vector register address.
REQ-009 req_vd  input  4  destination vector register address.
REQ-010 req_imm  input  WIDTH  scalar operand applied to every lane.
REQ-011 vrf_ra  output  4  vector register file read address (latched va).
REQ-012 vrf_rlane  output  3  lane index being read.
REQ-013 vrf_rdata  input  WIDTH  combinational read data for (vrf_ra, vrf_rlane).
REQ-014 vrf_we  output  1  lane write enable.
REQ-015 vrf_wa  output  4  destination vector address (latched vd).
REQ-016 vrf_wlane  output  3  lane index being written.
REQ-017 vrf_wdata  output  WIDTH  lane result.
REQ-018 busy  output  1  stall to the core; high whenever state is not IDLE.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 IDLE: req_ready=1, busy=0, vrf_we=0; on req_valid, latch op/va/vd/imm, clear lane counter and go to RUN.
REQ-022 RUN: each cycle, read lane L, compute the result, assert vrf_we with vrf_wlane=vrf_rlane=L, then increment L.
REQ-023 RUN SHALL last exactly NLANES cycles; from lane NLANES-1 the FSM goes to DONE and the counter wraps to 0.
REQ-024 DONE: done=1, busy=1, req_ready=0, vrf_we=0 for one cycle, then IDLE.
REQ-025 Latency: request accepted at edge T -> lane writes in cycles T+1..T+NLANES -> done in cycle T+NLANES+1 -> req_ready=1 in cycle T+NLANES+2.
REQ-026 Lane result = vrf_rdata OP imm; sub = vrf_rdata - imm; add/sub wrap modulo 2^WIDTH; no flags are produced.
REQ-027 Codes 100-111 SHALL write vrf_rdata unmodified.
REQ-028 req_valid while req_ready=0 SHALL be ignored; no queuing.
REQ-029 va==vd SHALL be legal; each lane is read before it is written in the same cycle, so in-place results are correct.
REQ-030 Latched operands SHALL NOT change if req_* inputs change during RUN.
REQ-031 vrf_ra/vrf_wa SHALL hold latched values in all states; vrf_wdata is don't-care when vrf_we=0.

Reset
REQ-032 Reset SHALL force state=IDLE, lane counter=0, latched operands=0 on the next edge.
REQ-033 After reset: req_ready=1, busy=0, done=0, vrf_we=0.
REQ-034 Reset during RUN SHALL abort with no further writes; lanes already written stay written.
REQ-035 reset and req_valid in the same cycle SHALL resolve as reset; the request is dropped.

Structure
REQ-036 Shared package vec_pkg SHALL hold NLANES, the 3-bit op encodings and the state enum.
REQ-037 Per-lane arithmetic SHALL sit in one sub-module, lane_alu (a, b, op -> y), purely combinational.
REQ-038 FSM, counter and operand latches SHALL reside in vec_lane_sequencer.

Verification
REQ-039 Bench: reset, then v1=[1,2,3,4,5]; add va=1, vd=2, imm=10 -> v2=[11,12,13,14,15]; done at T+6; busy high for cycles T+1..T+6.
REQ-040 Bench: sub imm=1 on lane value 0 -> 32'hFFFFFFFF; add imm=1 on 32'hFFFFFFFF -> 0.
REQ-041 Bench: in-place and, va=vd=3, v3=all 32'hF0F0F0F0, imm=32'h0FF00FF0 -> all 32'h00F000F0.
REQ-042 Bench: req_valid held high through RUN with different operands -> exactly one operation executes; the second request is accepted at T+7.
REQ-043 Bench: reset asserted in the 3rd RUN cycle -> lanes 0-1 written, lanes 2-4 unchanged; next cycle busy=0, req_ready=1.
REQ-044 Bench: op=3'b101 -> destination equals source lane-for-lane; done pulses exactly once.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector lane sequencer: lane count, ALU op codes
// and the sequencer state encoding.
package vec_pkg;

  localparam int NLANES = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lane_alu.sv
// Per-lane arithmetic: y = a OP b. Add/sub wrap, codes 100-111 pass a through.
module lane_alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);
  import vec_pkg::*;

  // Operation select; any non-arithmetic code is a plain copy.
  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Walks one vector operation across NLANES lanes, one lane per cycle, reading
// and writing the vector register file in the same cycle.
module vec_lane_sequencer #(
  parameter int NLANES = vec_pkg::NLANES,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [3:0]       req_va,
  input  logic [3:0]       req_vd,
  input  logic [WIDTH-1:0] req_imm,
  output logic [3:0]       vrf_ra,
  output logic [2:0]       vrf_rlane,
  input  logic [WIDTH-1:0] vrf_rdata,
  output logic             vrf_we,
  output logic [3:0]       vrf_wa,
  output logic [2:0]       vrf_wlane,
  output logic [WIDTH-1:0] vrf_wdata,
  output logic             busy,
  output logic             done
);
  import vec_pkg::*;

  localparam logic [2:0] LAST_LANE = 3'(NLANES - 1);

  state_t           state_r;
  logic [2:0]       lane_r;
  logic [2:0]       op_r;
  logic [3:0]       va_r;
  logic [3:0]       vd_r;
  logic [WIDTH-1:0] imm_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             we_r;
  logic [WIDTH-1:0] alu_y_s;

  lane_alu #(.WIDTH(WIDTH)) u_lane_alu (
    .a  (vrf_rdata),
    .b  (imm_r),
    .op (op_r),
    .y  (alu_y_s)
  );

  // Sequencer FSM with lane counter, operand latches and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      lane_r  <= 3'd0;
      op_r    <= 3'd0;
      va_r    <= 4'd0;
      vd_r    <= 4'd0;
      imm_r   <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r    <= req_op;
            va_r    <= req_va;
            vd_r    <= req_vd;
            imm_r   <= req_imm;
            lane_r  <= 3'd0;
            state_r <= ST_RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            we_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (lane_r == LAST_LANE) begin
            lane_r  <= 3'd0;
            state_r <= ST_DONE;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            lane_r  <= lane_r + 3'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          lane_r  <= 3'd0;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  // The write strobe is gated by reset so an aborted run commits nothing more.
  assign vrf_we    = we_r & ~reset;
  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign vrf_ra    = va_r;
  assign vrf_wa    = vd_r;
  assign vrf_rlane = lane_r;
  assign vrf_wlane = lane_r;
  assign vrf_wdata = alu_y_s;

endmodule
